// File: rtl/dm_dump_pkg.sv
// Shared types and helpers for the data-memory dump reader.
// Holds the FSM state enum, address/word constants and the checksum rotate.
package dm_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_OUT,
        ST_DONE
    } dump_state_e;

    localparam int WORD_BYTES  = 4;
    localparam int DUMP_ADDR_W = 16;
    localparam int DUMP_DATA_W = 32;

    function automatic logic [DUMP_DATA_W-1:0] rotl1(
        input logic [DUMP_DATA_W-1:0] v
    );
        return {v[DUMP_DATA_W-2:0], v[DUMP_DATA_W-1]};
    endfunction

endpackage

// File: rtl/dm_dump_out_reg.sv
// Valid/ready holding register for the dump output stream.
// Ports: clock/reset, load + load_addr/load_data in, ready in,
// valid/addr/data out; contents held until the sink accepts.
module dm_dump_out_reg
    import dm_dump_pkg::*;
#(
    parameter int ADDR_W = DUMP_ADDR_W,
    parameter int DATA_W = DUMP_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            addr  <= load_addr;
            data  <= load_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dm_dump_reader.sv
// Walks a word range of SRAM_dm through its test port and streams
// (address, data) pairs out on a valid/ready interface.
// Ports: clock, reset (sync, active-high); io_start/io_base_addr/
// io_word_count request; io_busy/io_done status; io_out_* stream;
// io_mem_read_test/io_mem_addr_test/io_mem_data_test memory test port.
// Optional DM_DUMP_CHECKSUM_EN adds io_checksum (rotl-xor of words).
module dm_dump_reader
    import dm_dump_pkg::*;
#(
    parameter int ADDR_W       = DUMP_ADDR_W,
    parameter int DATA_W       = DUMP_DATA_W,
    parameter int READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_start,
    input  logic [ADDR_W-1:0] io_base_addr,
    input  logic [ADDR_W-1:0] io_word_count,
    output logic              io_busy,
    output logic              io_done,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [31:0]       io_out_addr,
    output logic [DATA_W-1:0] io_out_data,
`ifdef DM_DUMP_CHECKSUM_EN
    output logic [DATA_W-1:0] io_checksum,
`endif
    output logic              io_mem_read_test,
    output logic [31:0]       io_mem_addr_test,
    input  logic [DATA_W-1:0] io_mem_data_test
);

    localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY - 1);

    dump_state_e       state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] rem_q;
    logic [1:0]        wcnt_q;
    logic              done_q;
    logic              out_load;
    logic              hs;
    logic [ADDR_W-1:0] out_addr_w;

    assign hs = (state == ST_OUT) && io_out_valid && io_out_ready;

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (io_start)
                    state_nx = (io_word_count == '0) ? ST_DONE : ST_REQ;
            end
            ST_REQ:  state_nx = ST_WAIT;
            ST_WAIT: begin
                if (wcnt_q == 2'd0) state_nx = ST_OUT;
            end
            ST_OUT: begin
                // rem still holds the pre-decrement count here
                if (hs)
                    state_nx = (rem_q == ADDR_W'(1)) ? ST_DONE : ST_REQ;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        io_busy          = 1'b0;
        io_mem_read_test = 1'b0;
        io_mem_addr_test = '0;
        out_load         = 1'b0;
        unique case (state)
            ST_REQ: begin
                io_busy          = 1'b1;
                io_mem_read_test = 1'b1;
                io_mem_addr_test = 32'(addr_q);
            end
            ST_WAIT: begin
                io_busy  = 1'b1;
                out_load = (wcnt_q == 2'd0);
            end
            ST_OUT:  io_busy = 1'b1;
            default: io_busy = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q <= '0;
            rem_q  <= '0;
            wcnt_q <= '0;
            done_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (io_start) begin
                        addr_q <= io_base_addr & ~ADDR_W'(WORD_BYTES - 1);
                        rem_q  <= io_word_count;
                        done_q <= 1'b0;
                    end
                end
                ST_REQ:  wcnt_q <= WAIT_INIT;
                ST_WAIT: begin
                    if (wcnt_q != 2'd0) wcnt_q <= wcnt_q - 2'd1;
                end
                ST_OUT: begin
                    if (hs) begin
                        rem_q  <= rem_q - ADDR_W'(1);
                        addr_q <= addr_q + ADDR_W'(WORD_BYTES);
                    end
                end
                ST_DONE: done_q <= 1'b1;
                default: ;
            endcase
        end
    end

`ifdef DM_DUMP_CHECKSUM_EN
    always_ff @(posedge clock) begin
        if (reset)
            io_checksum <= '0;
        else if (state == ST_IDLE && io_start)
            io_checksum <= '0;
        else if (hs)
            io_checksum <= rotl1(io_checksum) ^ io_out_data;
    end
`endif

    dm_dump_out_reg #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_out_reg (
        .clock    (clock),
        .reset    (reset),
        .load     (out_load),
        .load_addr(addr_q),
        .load_data(io_mem_data_test),
        .ready    (io_out_ready),
        .valid    (io_out_valid),
        .addr     (out_addr_w),
        .data     (io_out_data)
    );

    assign io_out_addr = 32'(out_addr_w);
    assign io_done     = done_q;

endmodule

// File: tb/tb_dm_dump_reader.sv
// Scoreboard bench for dm_dump_reader with a 1-cycle test-port memory.
// Expected pairs are queued at start and popped on each handshake.
module tb_dm_dump_reader;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_start;
    logic [15:0] io_base_addr;
    logic [15:0] io_word_count;
    logic        io_busy;
    logic        io_done;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [31:0] io_out_addr;
    logic [31:0] io_out_data;
    logic        io_mem_read_test;
    logic [31:0] io_mem_addr_test;
    logic [31:0] io_mem_data_test = '0;
`ifdef DM_DUMP_CHECKSUM_EN
    logic [31:0] io_checksum;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem [0:16383];
    int          nerr = 0;
    int          nchk = 0;
    int          strobes = 0;
    int          vcount = 0;
    logic [31:0] cs_model;

    always #5 clock = ~clock;

    dm_dump_reader dut (
        .clock           (clock),
        .reset           (reset),
        .io_start        (io_start),
        .io_base_addr    (io_base_addr),
        .io_word_count   (io_word_count),
        .io_busy         (io_busy),
        .io_done         (io_done),
        .io_out_valid    (io_out_valid),
        .io_out_ready    (io_out_ready),
        .io_out_addr     (io_out_addr),
        .io_out_data     (io_out_data),
`ifdef DM_DUMP_CHECKSUM_EN
        .io_checksum     (io_checksum),
`endif
        .io_mem_read_test(io_mem_read_test),
        .io_mem_addr_test(io_mem_addr_test),
        .io_mem_data_test(io_mem_data_test)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // memory test port: data valid one cycle after the strobe
    initial forever begin
        @(posedge clock);
        if (io_mem_read_test)
            io_mem_data_test <= mem[io_mem_addr_test[15:2]];
    end

    // output monitor: scoreboard pop and hold-stability check
    initial begin
        logic        held;
        logic [31:0] ha, hd;
        exp_t        e;
        held = 1'b0;
        ha = '0;
        hd = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                held = 1'b0;
            end else begin
                if (io_mem_read_test) strobes++;
                if (io_out_valid) vcount++;
                if (io_out_valid && held) begin
                    check("hold_addr", io_out_addr, ha);
                    check("hold_data", io_out_data, hd);
                end
                if (io_out_valid && io_out_ready) begin
                    if (q.size() == 0) begin
                        check("extra_out", io_out_addr, 32'hFFFF_FFFF);
                    end else begin
                        e = q.pop_front();
                        check("out_addr", io_out_addr, e.a);
                        check("out_data", io_out_data, e.d);
                        cs_model = {cs_model[30:0], cs_model[31]} ^ e.d;
                    end
                end
                held = io_out_valid && !io_out_ready;
                ha = io_out_addr;
                hd = io_out_data;
            end
        end
    end

    task automatic start_dump(input logic [15:0] base, input logic [15:0] cnt,
                              input bit expect_run);
        logic [15:0] a;
        exp_t        e;
        io_base_addr  = base;
        io_word_count = cnt;
        io_start      = 1'b1;
        if (expect_run) begin
            cs_model = '0;
            a = base & 16'hFFFC;
            for (int i = 0; i < int'(cnt); i++) begin
                e.a = {16'h0, a};
                e.d = mem[a[15:2]];
                q.push_back(e);
                a = a + 16'd4;
            end
        end
        tick();
        io_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!io_done && n < budget) begin
            tick();
            n++;
        end
        check("done_timeout", {31'h0, io_done}, 32'h1);
    endtask

    initial begin
        int s0, v0;
        for (int i = 0; i < 16384; i++) mem[i] = 32'hA500_0000 + i;
        reset         = 1'b1;
        io_start      = 1'b1;
        io_base_addr  = 16'h0010;
        io_word_count = 16'd4;
        io_out_ready  = 1'b1;
        tick();
        tick();
        check("rst_valid", {31'h0, io_out_valid}, 32'h0);
        check("rst_busy", {31'h0, io_busy}, 32'h0);
        check("rst_done", {31'h0, io_done}, 32'h0);
        check("rst_rd", {31'h0, io_mem_read_test}, 32'h0);
        check("rst_maddr", io_mem_addr_test, 32'h0);
        check("rst_oaddr", io_out_addr, 32'h0);
        check("rst_odata", io_out_data, 32'h0);
        io_start = 1'b0;
        reset    = 1'b0;
        tick();
        check("post_rst_busy", {31'h0, io_busy}, 32'h0);

        // basic dump and first-word latency
        start_dump(16'h0010, 16'd4, 1'b1);
        check("busy_c1", {31'h0, io_busy}, 32'h1);
        check("rd_c1", {31'h0, io_mem_read_test}, 32'h1);
        check("maddr_c1", io_mem_addr_test, 32'h10);
        tick();
        check("valid_c2", {31'h0, io_out_valid}, 32'h0);
        tick();
        check("valid_c3", {31'h0, io_out_valid}, 32'h1);
        wait_done(50);
        check("basic_left", q.size(), 0);
        check("basic_busy", {31'h0, io_busy}, 32'h0);

        // zero-length dump
        s0 = strobes;
        v0 = vcount;
        start_dump(16'h0040, 16'd0, 1'b1);
        check("z_done_c1", {31'h0, io_done}, 32'h0);
        tick();
        check("z_done_c2", {31'h0, io_done}, 32'h1);
        check("z_strobes", strobes - s0, 0);
        check("z_valids", vcount - v0, 0);

        // backpressure on the second word
        s0 = strobes;
        start_dump(16'h0100, 16'd3, 1'b1);
        for (int n = 0; n < 40; n++) begin
            if (io_out_valid && io_out_addr == 32'h104) break;
            tick();
        end
        check("bp_reach", io_out_addr, 32'h104);
        io_out_ready = 1'b0;
        repeat (5) tick();
        check("bp_strobes_stall", strobes - s0, 2);
        io_out_ready = 1'b1;
        wait_done(50);
        check("bp_strobes", strobes - s0, 3);
        check("bp_left", q.size(), 0);

        // address wrap
        start_dump(16'hFFF8, 16'd4, 1'b1);
        wait_done(50);
        check("wrap_left", q.size(), 0);

        // start while busy is ignored; low base bits dropped
        s0 = strobes;
        start_dump(16'h0202, 16'd3, 1'b1);
        tick();
        io_base_addr  = 16'h0800;
        io_word_count = 16'd2;
        io_start      = 1'b1;
        tick();
        io_start = 1'b0;
        wait_done(50);
        check("busy_st_left", q.size(), 0);
        check("busy_st_strobes", strobes - s0, 3);

        // reset mid-dump, then a fresh dump
        start_dump(16'h0300, 16'd4, 1'b1);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check("mid_valid", {31'h0, io_out_valid}, 32'h0);
        check("mid_busy", {31'h0, io_busy}, 32'h0);
        check("mid_done", {31'h0, io_done}, 32'h0);
        check("mid_oaddr", io_out_addr, 32'h0);
        check("mid_odata", io_out_data, 32'h0);
        reset = 1'b0;
        q.delete();
        tick();
        check("mid_done2", {31'h0, io_done}, 32'h0);
        start_dump(16'h0340, 16'd2, 1'b1);
        wait_done(50);
        check("fresh_left", q.size(), 0);

`ifdef DM_DUMP_CHECKSUM_EN
        mem[16'h0080] = 32'h1;
        mem[16'h0081] = 32'h2;
        mem[16'h0082] = 32'h4;
        start_dump(16'h0200, 16'd3, 1'b1);
        wait_done(50);
        check("cs_value", io_checksum, cs_model);
        tick();
        check("cs_stable", io_checksum, cs_model);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
